// File: rtl/argmax_stream.sv
// ---------------------------------------------------------------------------
// argmax_stream
//
// Purpose:
//   Streaming argmax over one vector of NUM_CLASSES class scores. Scores
//   arrive one per cycle on a valid/ready input channel, and the largest
//   score plus its class index are presented on a valid/ready result
//   channel. Scores are compared as unsigned DATA_WIDTH-bit values, which
//   orders non-negative IEEE-754 numbers (e.g. softmax outputs) correctly.
//   When two scores are equal, the lower class index wins.
//
// Optional feature:
//   ARGMAX_RUNNERUP_EN - when defined, adds second_value/second_index outputs
//                        that report the runner-up score and its class index.
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset        in   asynchronous reset, active low
//   in_valid     in   in_data/in_last valid this cycle
//   in_ready     out  block accepts a score this cycle
//   in_data      in   one class score, class order 0..NUM_CLASSES-1
//   in_last      in   final score of the vector
//   out_valid    out  result available
//   out_ready    in   consumer takes the result this cycle
//   max_value    out  largest score of the vector
//   max_index    out  class index of max_value
//   len_error    out  in_last position did not match NUM_CLASSES
//   done         out  one-cycle pulse after a result is taken
//   second_value out  runner-up score        (ARGMAX_RUNNERUP_EN only)
//   second_index out  runner-up class index  (ARGMAX_RUNNERUP_EN only)
// ---------------------------------------------------------------------------
module argmax_stream #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] max_value,
    output logic [IDX_WIDTH-1:0]  max_index,
    output logic                  len_error,
    output logic                  done
`ifdef ARGMAX_RUNNERUP_EN
    ,
    output logic [DATA_WIDTH-1:0] second_value,
    output logic [IDX_WIDTH-1:0]  second_index
`endif
);

    // count holds the position of the next score, so it must reach NUM_CLASSES
    localparam int CNT_WIDTH = $clog2(NUM_CLASSES + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_POS = CNT_WIDTH'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_WIDTH-1:0] count;
    logic                 accept;
    logic                 scan_end;
    logic [IDX_WIDTH-1:0] pos_index;

    assign accept    = in_valid & in_ready;
    assign pos_index = IDX_WIDTH'(count);
    // A vector also ends when the last legal position is reached without in_last
    assign scan_end  = in_last | (count == LAST_POS);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = in_last ? HOLD : SCAN;
                end
            end
            SCAN: begin
                if (accept && scan_end) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs; in_ready is gated by reset so it stays low while reset is held
    always_comb begin
        in_ready  = reset & (state != HOLD);
        out_valid = (state == HOLD);
    end

    // Running maximum, position counter, length check and done pulse.
    // The running registers drive the outputs directly, so they keep the
    // previous result until the first score of the next vector overwrites them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            max_value <= '0;
            max_index <= '0;
            len_error <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == HOLD) & out_ready;
            if (accept) begin
                if (state == IDLE) begin
                    max_value <= in_data;
                    max_index <= '0;
                    count     <= CNT_WIDTH'(1);
                    // in_last on position 0 is always early since NUM_CLASSES >= 2
                    len_error <= in_last;
                end else if (state == SCAN) begin
                    if (in_data > max_value) begin
                        max_value <= in_data;
                        max_index <= pos_index;
                    end
                    count <= count + CNT_WIDTH'(1);
                    if (scan_end) begin
                        // Without in_last the vector only ends at the last position
                        len_error <= in_last ? (count != LAST_POS) : 1'b1;
                    end
                end
            end
        end
    end

`ifdef ARGMAX_RUNNERUP_EN
    // Runner-up tracking. have_second marks that the runner-up holds a real
    // score of the current vector, so the first non-max score always lands
    // there even if it is zero. A displaced maximum becomes the runner-up;
    // a score equal to the runner-up never replaces it (lower index kept).
    logic have_second;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            second_value <= '0;
            second_index <= '0;
            have_second  <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                second_value <= '0;
                second_index <= '0;
                have_second  <= 1'b0;
            end else if (state == SCAN) begin
                have_second <= 1'b1;
                if (in_data > max_value) begin
                    second_value <= max_value;
                    second_index <= max_index;
                end else if (!have_second || (in_data > second_value)) begin
                    second_value <= in_data;
                    second_index <= pos_index;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_argmax_stream.sv
// ---------------------------------------------------------------------------
// tb_argmax_stream
//
// Directed self-checking bench for argmax_stream with default parameters
// (32-bit scores, 10 classes). Inputs change #1 after the rising edge and
// outputs are sampled at the same point, away from the active edge.
// Runner-up checks are compiled in only when ARGMAX_RUNNERUP_EN is defined.
// ---------------------------------------------------------------------------
module tb_argmax_stream;

    localparam int DW = 32;
    localparam int NC = 10;
    localparam int IW = $clog2(NC);

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] max_value;
    logic [IW-1:0] max_index;
    logic          len_error;
    logic          done;
`ifdef ARGMAX_RUNNERUP_EN
    logic [DW-1:0] second_value;
    logic [IW-1:0] second_index;
`endif

    int checks;
    int failures;

    logic [DW-1:0] vec [NC];

    argmax_stream #(
        .DATA_WIDTH (DW),
        .NUM_CLASSES(NC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .max_value(max_value),
        .max_index(max_index),
        .len_error(len_error),
        .done     (done)
`ifdef ARGMAX_RUNNERUP_EN
        ,
        .second_value(second_value),
        .second_index(second_index)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Send the first n entries of vec; in_last is raised on position lastAt
    // (-1 for none). With gap set, an idle cycle carrying junk data and
    // in_last=1 is inserted between beats.
    task automatic applyStimulus(input int n, input int lastAt, input bit gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            in_last  = (i == lastAt);
            nextCycle();
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (gap && (i < n - 1)) begin
                in_data = '1;
                in_last = 1'b1;
                nextCycle();
                in_last = 1'b0;
            end
        end
        in_data = '0;
    endtask

    // Check a pending result, take it, and check the done pulse
    task automatic checkResult(input string tag, input logic [DW-1:0] expVal,
                               input logic [IW-1:0] expIdx, input logic expErr,
                               input logic [DW-1:0] expSec, input logic [IW-1:0] expSecIdx);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        checkOutput({tag, "_max_value"}, 64'(max_value), 64'(expVal));
        checkOutput({tag, "_max_index"}, 64'(max_index), 64'(expIdx));
        checkOutput({tag, "_len_error"}, 64'(len_error), 64'(expErr));
`ifdef ARGMAX_RUNNERUP_EN
        checkOutput({tag, "_second_value"}, 64'(second_value), 64'(expSec));
        checkOutput({tag, "_second_index"}, 64'(second_index), 64'(expSecIdx));
`else
        if (expSec != expSec || expSecIdx != expSecIdx) begin
            $display("[TB] unexpected X in runner-up expectation");
        end
`endif
        checkOutput({tag, "_done_before"}, 64'(done), 64'd0);
        out_ready = 1'b1;
        nextCycle();
        out_ready = 1'b0;
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'd1);
        checkOutput({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_max_value_kept"}, 64'(max_value), 64'(expVal));
        nextCycle();
        checkOutput({tag, "_done_single"}, 64'(done), 64'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        nextCycle();
        nextCycle();
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_max_value", 64'(max_value), 64'd0);
        checkOutput("rst_max_index", 64'(max_index), 64'd0);
        checkOutput("rst_len_error", 64'(len_error), 64'd0);
        reset = 1'b1;
        #1;
        checkOutput("rel_in_ready", 64'(in_ready), 64'd1);
        nextCycle();

        // Basic vector with a tie at the maximum
        vec = '{32'd1, 32'd5, 32'd3, 32'd9, 32'd2, 32'd9, 32'd0, 32'd4, 32'd7, 32'd6};
        applyStimulus(10, 9, 1'b0);
        checkResult("basic", 32'd9, 4'd3, 1'b0, 32'd9, 4'd5);

        // Same vector with in_valid toggling and junk on idle cycles
        applyStimulus(10, 9, 1'b1);
        checkResult("toggle", 32'd9, 4'd3, 1'b0, 32'd9, 4'd5);

        // Consumer stalls for 5 cycles; input attempts during HOLD are ignored
        vec = '{32'd3, 32'd1, 32'd4, 32'd1, 32'd5, 32'd9, 32'd2, 32'd6, 32'd5, 32'd3};
        applyStimulus(10, 9, 1'b0);
        in_valid = 1'b1;
        in_data  = '1;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_max_value", 64'(max_value), 64'd9);
            checkOutput("stall_max_index", 64'(max_index), 64'd5);
            checkOutput("stall_done", 64'(done), 64'd0);
            nextCycle();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        checkResult("stall", 32'd9, 4'd5, 1'b0, 32'd6, 4'd7);

        // Early in_last on the 4th score
        vec = '{32'd2, 32'd8, 32'd8, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        applyStimulus(4, 3, 1'b0);
        checkResult("short", 32'd8, 4'd1, 1'b1, 32'd8, 4'd2);

        // Following full vector clears the length error; max on last position
        vec = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7};
        applyStimulus(10, 9, 1'b0);
        checkResult("full", 32'd7, 4'd9, 1'b0, 32'd0, 4'd0);

        // Ten scores without in_last: vector ends on count, length error set
        vec = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
        applyStimulus(10, -1, 1'b0);
        checkResult("nolast", 32'd10, 4'd9, 1'b1, 32'd9, 4'd8);

        // Reset after 6 accepted scores discards the partial vector
        vec = '{32'd50, 32'd60, 32'd70, 32'd80, 32'd90, 32'd99, 32'd0, 32'd0, 32'd0, 32'd0};
        applyStimulus(6, -1, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("midrst_max_value", 64'(max_value), 64'd0);
        checkOutput("midrst_max_index", 64'(max_index), 64'd0);
        checkOutput("midrst_len_error", 64'(len_error), 64'd0);
        nextCycle();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("midrst_no_done", 64'(done), 64'd0);
            checkOutput("midrst_idle_out_valid", 64'(out_valid), 64'd0);
            nextCycle();
        end

        // Full-width unsigned compare on the last position
        vec = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
        applyStimulus(10, 9, 1'b0);
        checkResult("fullwidth", 32'hFFFF_FFFF, 4'd9, 1'b0, 32'd0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
